// File: rtl/serdes_shifter_pkg.sv
// Shared types and encodings for the serialiser/deserialiser shift register.
package serdes_shifter_pkg;

    // Transfer state machine states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Source of the bit inserted at the far end of the register on each shift.
    localparam logic LOOP_EXT = 1'b0;  // external serial input
    localparam logic LOOP_ROT = 1'b1;  // outgoing bit fed back (rotate)

endpackage

// File: rtl/serdes_shifter_bit_src_mux.sv
// Chooses the bit that enters the shift register: external serial input or
// the bit currently leaving (rotate).
module bit_src_mux
    import serdes_shifter_pkg::*;
(
    input  logic loop_sel,
    input  logic ser_in,
    input  logic ser_out,
    output logic ins_bit
);

    // Select the inserted bit from loop_sel.
    always_comb begin
        ins_bit = ser_in;
        if (loop_sel == LOOP_ROT) begin
            ins_bit = ser_out;
        end
    end

endmodule

// File: rtl/serdes_shifter.sv
// Parallel-to-serial / serial-to-parallel shift register with a three-state
// transfer FSM (load, shift WIDTH bits, hand the word back).
module serdes_shifter
    import serdes_shifter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    input  logic             ser_in,
    input  logic             loop_sel,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    input  logic             abort
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic             load_ready_reg;
    logic             ser_valid_reg;
    logic             par_valid_reg;
    logic             ins_bit;
    logic             last_shift;

    // The outgoing bit sits at the output end; the opposite end receives ins_bit.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign ser_out    = shreg_reg[WIDTH-1];
            assign shreg_next = {shreg_reg[WIDTH-2:0], ins_bit};
        end else begin : g_lsb_first
            assign ser_out    = shreg_reg[0];
            assign shreg_next = {ins_bit, shreg_reg[WIDTH-1:1]};
        end
    endgenerate

    bit_src_mux u_bit_src_mux (
        .loop_sel (loop_sel),
        .ser_in   (ser_in),
        .ser_out  (ser_out),
        .ins_bit  (ins_bit)
    );

    assign last_shift = (cnt_reg == CW'(WIDTH - 1));

    assign load_ready = load_ready_reg;
    assign ser_valid  = ser_valid_reg;
    assign par_valid  = par_valid_reg;
    assign par_out    = shreg_reg;

    // Transfer FSM, bit counter, shift register and registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shreg_reg      <= '0;
            load_ready_reg <= 1'b1;
            ser_valid_reg  <= 1'b0;
            par_valid_reg  <= 1'b0;
        end else if (abort) begin
            // Cancel without touching shreg and without a par_valid pulse.
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            load_ready_reg <= 1'b1;
            ser_valid_reg  <= 1'b0;
            par_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        shreg_reg      <= par_in;
                        cnt_reg        <= '0;
                        state_reg      <= SHIFT;
                        load_ready_reg <= 1'b0;
                        ser_valid_reg  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ser_en) begin
                        shreg_reg <= shreg_next;
                        if (last_shift) begin
                            // Counter is parked at zero so it never passes WIDTH-1.
                            cnt_reg       <= '0;
                            state_reg     <= DONE;
                            ser_valid_reg <= 1'b0;
                            par_valid_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A load offered in this same cycle is ignored: load_ready is low.
                    if (par_ready) begin
                        state_reg      <= IDLE;
                        par_valid_reg  <= 1'b0;
                        load_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    cnt_reg        <= '0;
                    load_ready_reg <= 1'b1;
                    ser_valid_reg  <= 1'b0;
                    par_valid_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_shifter.sv
// Self-checking bench: an MSB-first and an LSB-first instance share every
// input; expected bit streams and final words come from a transfer-level model.
module tb_serdes_shifter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] par_in;
    logic         load_valid;
    logic         ser_en;
    logic         ser_in;
    logic         loop_sel;
    logic         par_ready;
    logic         abort;

    logic         load_ready_m, ser_out_m, ser_valid_m, par_valid_m;
    logic [W-1:0] par_out_m;
    logic         load_ready_l, ser_out_l, ser_valid_l, par_valid_l;
    logic [W-1:0] par_out_l;

    int errors = 0;
    int checks = 0;

    serdes_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .par_in(par_in), .load_valid(load_valid),
        .load_ready(load_ready_m), .ser_en(ser_en), .ser_in(ser_in),
        .loop_sel(loop_sel), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .par_out(par_out_m), .par_valid(par_valid_m), .par_ready(par_ready),
        .abort(abort)
    );

    serdes_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .par_in(par_in), .load_valid(load_valid),
        .load_ready(load_ready_l), .ser_en(ser_en), .ser_in(ser_in),
        .loop_sel(loop_sel), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .par_out(par_out_l), .par_valid(par_valid_l), .par_ready(par_ready),
        .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " load_ready_m"}, 32'(load_ready_m), 32'd1);
        check({tag, " load_ready_l"}, 32'(load_ready_l), 32'd1);
        check({tag, " ser_valid_m"}, 32'(ser_valid_m), 32'd0);
        check({tag, " ser_valid_l"}, 32'(ser_valid_l), 32'd0);
        check({tag, " par_valid_m"}, 32'(par_valid_m), 32'd0);
        check({tag, " par_valid_l"}, 32'(par_valid_l), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_idle(tag);
        check({tag, " ser_out_m"}, 32'(ser_out_m), 32'd0);
        check({tag, " ser_out_l"}, 32'(ser_out_l), 32'd0);
        check({tag, " par_out_m"}, 32'(par_out_m), 32'd0);
        check({tag, " par_out_l"}, 32'(par_out_l), 32'd0);
    endtask

    // One transfer. Bits are numbered in transmit order k = 0..W-1.
    // ext: ext[W-1-k] is driven on ser_in for shift k.
    // stall_after/abort_after/reset_after: event after bit k is shown (>= W: never).
    task automatic do_transfer(input string name, input logic [W-1:0] word,
                               input logic [W-1:0] ext, input logic rot,
                               input int stall_after, input int stall_len,
                               input int bp_len, input int abort_after,
                               input int reset_after);
        logic [W-1:0] exp_m;
        logic [W-1:0] exp_l;
        logic         bit_m, bit_l, sin;
        exp_m = '0;
        exp_l = '0;
        check_idle({name, " pre"});
        par_in     = word;
        load_valid = 1'b1;
        loop_sel   = rot;
        ser_en     = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            bit_m = word[W-1-k];
            bit_l = word[k];
            check($sformatf("%s bit%0d ser_out_m", name, k), 32'(ser_out_m), 32'(bit_m));
            check($sformatf("%s bit%0d ser_out_l", name, k), 32'(ser_out_l), 32'(bit_l));
            check($sformatf("%s bit%0d ser_valid", name, k), 32'({ser_valid_m, ser_valid_l}), 32'd3);
            check($sformatf("%s bit%0d rdy/pv", name, k),
                  32'({load_ready_m, load_ready_l, par_valid_m, par_valid_l}), 32'd0);
            if (k == abort_after) begin
                abort     = 1'b1;
                par_ready = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                check_idle($sformatf("%s abort@%0d", name, k));
                check($sformatf("%s abort hold m", name), 32'(ser_out_m), 32'(bit_m));
                check($sformatf("%s abort hold l", name), 32'(ser_out_l), 32'(bit_l));
                @(negedge clk);
                check($sformatf("%s abort no pv", name), 32'({par_valid_m, par_valid_l}), 32'd0);
                $display("xfer %s word=%02h aborted after bit %0d", name, word, k);
                return;
            end
            if (k == reset_after) begin
                rst_n = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                abort = 1'b0;
                check_reset_vals($sformatf("%s reset@%0d", name, k));
                @(negedge clk);
                check($sformatf("%s reset no pv", name), 32'({par_valid_m, par_valid_l}), 32'd0);
                $display("xfer %s word=%02h reset after bit %0d", name, word, k);
                return;
            end
            if (k == stall_after) begin
                ser_en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check($sformatf("%s stall%0d m", name, s), 32'(ser_out_m), 32'(bit_m));
                    check($sformatf("%s stall%0d l", name, s), 32'(ser_out_l), 32'(bit_l));
                    check($sformatf("%s stall%0d flags", name, s),
                          32'({ser_valid_m, ser_valid_l, par_valid_m, par_valid_l}), 32'hC);
                end
                ser_en = 1'b1;
            end
            sin    = ext[W-1-k];
            ser_in = sin;
            exp_m[W-1-k] = rot ? bit_m : sin;
            exp_l[k]     = rot ? bit_l : sin;
            @(negedge clk);
        end
        check({name, " done par_valid"}, 32'({par_valid_m, par_valid_l}), 32'd3);
        check({name, " done ser_valid"}, 32'({ser_valid_m, ser_valid_l}), 32'd0);
        check({name, " par_out_m"}, 32'(par_out_m), 32'(exp_m));
        check({name, " par_out_l"}, 32'(par_out_l), 32'(exp_l));
        par_ready = 1'b0;
        for (int b = 0; b < bp_len; b++) begin
            @(negedge clk);
            check($sformatf("%s bp%0d par_out_m", name, b), 32'(par_out_m), 32'(exp_m));
            check($sformatf("%s bp%0d par_out_l", name, b), 32'(par_out_l), 32'(exp_l));
            check($sformatf("%s bp%0d flags", name, b),
                  32'({par_valid_m, par_valid_l, load_ready_m, load_ready_l}), 32'hC);
        end
        // Offer a new word in the same cycle as par_ready; it must be ignored.
        par_ready  = 1'b1;
        load_valid = 1'b1;
        par_in     = ~word;
        @(negedge clk);
        load_valid = 1'b0;
        par_ready  = 1'b0;
        check_idle({name, " post"});
        @(negedge clk);
        check_idle({name, " no load"});
        $display("xfer %s word=%02h rot=%0d out_m=%02h out_l=%02h", name, word, rot, par_out_m, par_out_l);
    endtask

    initial begin
        rst_n      = 1'b0;
        par_in     = '0;
        load_valid = 1'b0;
        ser_en     = 1'b0;
        ser_in     = 1'b0;
        loop_sel   = 1'b0;
        par_ready  = 1'b0;
        abort      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        abort = 1'b0;
        @(negedge clk);

        do_transfer("rotate_a5", 8'hA5, 8'h00, 1'b1, 99, 0, 0, 99, 99);
        do_transfer("deser_3c", 8'h96, 8'h3C, 1'b0, 99, 0, 0, 99, 99);
        do_transfer("stall_bp", 8'h5B, 8'hC3, 1'b0, 3, 3, 5, 99, 99);
        do_transfer("abort", 8'hE7, 8'h00, 1'b1, 99, 0, 0, 4, 99);
        do_transfer("after_abort", 8'h0F, 8'h00, 1'b1, 99, 0, 0, 99, 99);
        do_transfer("reset", 8'h81, 8'h00, 1'b1, 99, 0, 0, 99, 5);
        do_transfer("after_reset", 8'hA5, 8'h00, 1'b1, 99, 0, 0, 99, 99);

        for (int i = 0; i < 30; i++) begin
            do_transfer($sformatf("rand%0d", i),
                        W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 40)),
                        int'($urandom_range(0, 40)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serdes_shifter.md
SERDES_SHIFTER -- requirements
Module: serdes_shifter

Interface
REQ-001 Parameter WIDTH, default 8: shift register width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift MSB out first and insert at LSB; 0 = shift LSB out first and insert at MSB.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset.
REQ-005 Port par_in  input  WIDTH  parallel word to serialise.
REQ-006 Port load_valid  input  1  par_in is valid.
REQ-007 Port load_ready  output  1  block can accept a word.
REQ-008 Port ser_en  input  1  shift enable; low stalls shifting.
REQ-009 Port ser_in  input  1  external serial input bit.
REQ-010 Port loop_sel  input  1  inserted-bit source: 0 = ser_in, 1 = ser_out (rotate).
REQ-011 Port ser_out  output  1  current outgoing bit.
REQ-012 Port ser_valid  output  1  ser_out is a valid data bit.
REQ-013 Port par_out  output  WIDTH  deserialised word.
REQ-014 Port par_valid  output  1  par_out is valid.
REQ-015 Port par_ready  input  1  consumer accepts par_out.
REQ-016 Port abort  input  1  cancels the current transfer.

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 IDLE: load_ready=1, ser_valid=0, par_valid=0; load_valid=1 at a rising edge SHALL load shreg with par_in, clear cnt to 0 and enter SHIFT.
REQ-019 SHIFT: ser_valid=1, load_ready=0; ser_out = shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
REQ-020 SHIFT with ser_en=1 at a rising edge: shreg shifts one position toward the output end, the inserted bit comes from loop_sel's source, and cnt increments.
REQ-021 SHIFT with ser_en=0: shreg, cnt and ser_out SHALL hold unchanged.
REQ-022 The shift at which cnt==WIDTH-1 with ser_en=1 SHALL be the last shift and SHALL move the FSM to DONE; exactly WIDTH bits leave per transfer.
REQ-023 DONE: par_valid=1, par_out=shreg, ser_valid=0, load_ready=0; par_ready=1 SHALL return the FSM to IDLE.
REQ-024 In DONE with par_ready=0, par_out SHALL stay stable indefinitely.
REQ-025 In DONE, a load_valid in the same cycle as par_ready SHALL NOT be accepted; acceptance occurs no earlier than the following cycle in IDLE.
REQ-026 Latency: with ser_en held high, the load is accepted at edge t, bits are valid in cycles t+1..t+WIDTH, and par_valid rises after edge t+WIDTH.
REQ-027 abort=1 SHALL force IDLE on the next edge, from any state, clearing cnt; shreg SHALL be unchanged and no par_valid pulse SHALL occur.
REQ-028 abort SHALL take priority over load_valid, ser_en and par_ready.
REQ-029 cnt width SHALL be $clog2(WIDTH); cnt never exceeds WIDTH-1.
REQ-030 par_out SHALL be driven from shreg in all states; it is meaningful only while par_valid=1.

Reset
REQ-031 With rst_n=0 at a rising edge: state=IDLE, cnt=0, shreg=0.
REQ-032 Outputs after reset: load_ready=1, ser_valid=0, par_valid=0, ser_out=0, par_out=0.
REQ-033 Reset SHALL take priority over abort and every other input.
REQ-034 Reset asserted mid-transfer SHALL discard the transfer, with no par_valid pulse.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, SHIFT, DONE) and the loop_sel encodings LOOP_EXT=0 and LOOP_ROT=1.
REQ-036 One sub-module, bit_src_mux, SHALL select the inserted bit (ser_in or ser_out) from loop_sel; counter and FSM stay in serdes_shifter.

Verification
REQ-037 Rotate: WIDTH=8, MSB_FIRST=1, loop_sel=1, par_in=8'hA5, ser_en=1 -> ser_out 1,0,1,0,0,1,0,1 in cycles t+1..t+8; then par_valid=1 with par_out=8'hA5.
REQ-038 Deserialise: loop_sel=0, ser_in driven 0,0,1,1,1,1,0,0 over 8 shifts -> par_out=8'h3C in DONE.
REQ-039 Stall and back-pressure: ser_en low for 3 cycles after bit 3 -> ser_out holds and par_valid is delayed 3 cycles; par_ready low for 5 cycles -> par_out stable, load_ready=0.
REQ-040 Abort: abort after bit 4 -> IDLE next cycle, load_ready=1, no par_valid; a new load of 8'h0F then completes normally.
REQ-041 Reset mid-shift: rst_n=0 for one edge at bit 5 -> all outputs equal their reset values; MSB_FIRST=0 rerun with 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 (LSB first).
